// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the three-master external bus arbiter.
package bus_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  // Index of the master currently owning the bus.
  typedef logic [1:0] gnt_idx_t;

  localparam gnt_idx_t M_CPU = 2'd0;
  localparam gnt_idx_t M_VID = 2'd1;
  localparam gnt_idx_t M_DMA = 2'd2;

  // Wait-state and video-burst counters both fit in 4 bits (0..15).
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection: video first until its burst budget is
// spent, then CPU/DMA by round-robin pointer, then video again if nobody
// else wants the bus.
module arb_pick
  import bus_arb_pkg::*;
#(
  parameter int VID_BURST = 4
) (
  input  logic [2:0] req_i,        // {dma, vid, cpu}
  input  cnt_t       vid_cnt_i,    // consecutive video grants so far
  input  logic       ptr_i,        // 0 = CPU preferred, 1 = DMA preferred
  output logic       gnt_valid_o,
  output gnt_idx_t   gnt_idx_o
);

  localparam cnt_t VID_MAX = cnt_t'(VID_BURST);

  // Priority selection among the current requests.
  always_comb begin
    // NOTE: every output gets a default before the priority chain so no path
    // leaves it unassigned, which would otherwise infer a latch.
    gnt_valid_o = 1'b0;
    gnt_idx_o   = M_CPU;
    if (req_i[M_VID] && (vid_cnt_i < VID_MAX)) begin
      gnt_valid_o = 1'b1;
      gnt_idx_o   = M_VID;
    end else if (req_i[M_CPU] && req_i[M_DMA]) begin
      gnt_valid_o = 1'b1;
      gnt_idx_o   = ptr_i ? M_DMA : M_CPU;
    end else if (req_i[M_CPU]) begin
      gnt_valid_o = 1'b1;
      gnt_idx_o   = M_CPU;
    end else if (req_i[M_DMA]) begin
      gnt_valid_o = 1'b1;
      gnt_idx_o   = M_DMA;
    end else if (req_i[M_VID]) begin
      // Burst budget exhausted but the bus would otherwise sit idle.
      gnt_valid_o = 1'b1;
      gnt_idx_o   = M_VID;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// External 8-bit memory bus arbiter for CPU (m0), video (m1) and DMA (m2).
// Each access holds chip select for WAIT_STATES+1 cycles, then pulses the
// granted master's ack for one cycle alongside registered read data.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int VID_BURST   = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_m0_req,
  input  logic        i_m1_req,
  input  logic        i_m2_req,
  input  logic [15:0] i_m0_addr,
  input  logic [15:0] i_m1_addr,
  input  logic [15:0] i_m2_addr,
  input  logic        i_m0_we,
  input  logic        i_m1_we,
  input  logic        i_m2_we,
  input  logic [7:0]  i_m0_dat,
  input  logic [7:0]  i_m1_dat,
  input  logic [7:0]  i_m2_dat,
  output logic        o_m0_ack,
  output logic        o_m1_ack,
  output logic        o_m2_ack,
  output logic [7:0]  o_rdat,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_dat,
  output logic        o_mem_we,
  output logic        o_mem_cs,
  input  logic [7:0]  i_mem_dat,
  output logic        o_busy
);

  localparam cnt_t WAIT_LOAD = cnt_t'(WAIT_STATES);
  localparam cnt_t VID_MAX   = cnt_t'(VID_BURST);

  state_t     state_q, state_d;
  gnt_idx_t   gnt_q, gnt_d;
  cnt_t       wait_q, wait_d;
  cnt_t       vid_q, vid_d;
  logic       ptr_q, ptr_d;
  logic [7:0] rdat_q, rdat_d;

  logic       pick_valid;
  gnt_idx_t   pick_idx;

  logic [15:0] sel_addr;
  logic [7:0]  sel_dat;
  logic        sel_we;

  arb_pick #(
    .VID_BURST (VID_BURST)
  ) u_pick (
    .req_i       ({i_m2_req, i_m1_req, i_m0_req}),
    .vid_cnt_i   (vid_q),
    .ptr_i       (ptr_q),
    .gnt_valid_o (pick_valid),
    .gnt_idx_o   (pick_idx)
  );

  // Route the granted master's address, data and direction onto the bus.
  always_comb begin
    sel_addr = i_m0_addr;
    sel_dat  = i_m0_dat;
    sel_we   = i_m0_we;
    case (gnt_q)
      M_VID: begin
        sel_addr = i_m1_addr;
        sel_dat  = i_m1_dat;
        sel_we   = i_m1_we;
      end
      M_DMA: begin
        sel_addr = i_m2_addr;
        sel_dat  = i_m2_dat;
        sel_we   = i_m2_we;
      end
      default: ;
    endcase
  end

  // Next state, arbitration bookkeeping and read-data capture.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wait_d  = wait_q;
    vid_d   = vid_q;
    ptr_d   = ptr_q;
    rdat_d  = rdat_q;
    case (state_q)
      ST_IDLE, ST_ACK: begin
        // ACK is also an arbitration slot so back-to-back accesses lose no cycle.
        state_d = ST_IDLE;
        if (pick_valid) begin
          state_d = ST_ACCESS;
          gnt_d   = pick_idx;
          wait_d  = WAIT_LOAD;
          if (pick_idx == M_VID) begin
            if (vid_q < VID_MAX) vid_d = vid_q + 1'b1;
          end else begin
            vid_d = '0;
            ptr_d = ~ptr_q;
          end
        end
      end
      ST_ACCESS: begin
        if (wait_q == '0) begin
          state_d = ST_ACK;
          if (!sel_we) rdat_d = i_mem_dat;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and bookkeeping registers; reset aborts any access in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: registers update with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= M_CPU;
      wait_q  <= '0;
      vid_q   <= '0;
      ptr_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wait_q  <= wait_d;
      vid_q   <= vid_d;
      ptr_q   <= ptr_d;
      rdat_q  <= rdat_d;
    end
  end

  assign o_mem_cs   = (state_q == ST_ACCESS);
  assign o_mem_addr = o_mem_cs ? sel_addr : '0;
  assign o_mem_dat  = o_mem_cs ? sel_dat  : '0;
  assign o_mem_we   = o_mem_cs & sel_we;

  assign o_m0_ack = (state_q == ST_ACK) && (gnt_q == M_CPU);
  assign o_m1_ack = (state_q == ST_ACK) && (gnt_q == M_VID);
  assign o_m2_ack = (state_q == ST_ACK) && (gnt_q == M_DMA);

  assign o_rdat = rdat_q;
  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a scoreboard of expected grants
// (master and read data) is filled as requests are raised and drained by a
// monitor on every ack; the monitor also checks the bus pins each cycle.
module tb_bus_arbiter;

  localparam int WS    = 1;
  localparam int VB    = 4;
  localparam int SPACE = WS + 2;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [2:0]  req;
  logic [15:0] addr [3];
  logic [2:0]  we;
  logic [7:0]  dat [3];

  logic        o_m0_ack, o_m1_ack, o_m2_ack;
  logic [7:0]  o_rdat;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_dat;
  logic        o_mem_we, o_mem_cs, o_busy;
  logic [7:0]  mem_rdat;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int first_ack_cyc = 0;

  typedef struct packed {
    logic [1:0] m;
    logic [7:0] rdat;
  } exp_t;
  exp_t exp_q[$];

  bus_arbiter #(
    .WAIT_STATES (WS),
    .VID_BURST   (VB)
  ) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_m0_req   (req[0]),
    .i_m1_req   (req[1]),
    .i_m2_req   (req[2]),
    .i_m0_addr  (addr[0]),
    .i_m1_addr  (addr[1]),
    .i_m2_addr  (addr[2]),
    .i_m0_we    (we[0]),
    .i_m1_we    (we[1]),
    .i_m2_we    (we[2]),
    .i_m0_dat   (dat[0]),
    .i_m1_dat   (dat[1]),
    .i_m2_dat   (dat[2]),
    .o_m0_ack   (o_m0_ack),
    .o_m1_ack   (o_m1_ack),
    .o_m2_ack   (o_m2_ack),
    .o_rdat     (o_rdat),
    .o_mem_addr (o_mem_addr),
    .o_mem_dat  (o_mem_dat),
    .o_mem_we   (o_mem_we),
    .o_mem_cs   (o_mem_cs),
    .i_mem_dat  (mem_rdat),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Memory model: read data is a fixed function of the address (0x1234 -> 0xA5).
  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h83;
  endfunction

  assign mem_rdat = mem_fn(o_mem_addr);

  function automatic logic [37:0] all_outs();
    return {o_m0_ack, o_m1_ack, o_m2_ack, o_rdat, o_mem_addr, o_mem_dat,
            o_mem_we, o_mem_cs, o_busy};
  endfunction

  function automatic exp_t mk(input int m, input logic [15:0] a);
    exp_t e;
    e.m    = 2'(m);
    e.rdat = mem_fn(a);
    return e;
  endfunction

  // Bus and ack monitor, sampled on the falling edge.
  int cs_run = 0;
  always @(negedge i_clk) begin
    logic [2:0] acks;
    exp_t e;
    int m;
    if (!i_reset_n) begin
      cs_run = 0;
    end else begin
      acks = {o_m2_ack, o_m1_ack, o_m0_ack};
      n_vec++;
      if (o_busy !== (o_mem_cs | (|acks))) begin
        n_err++;
        $display("FAIL busy: got %b cs=%b acks=%b", o_busy, o_mem_cs, acks);
      end
      if (o_mem_cs === 1'b1) begin
        cs_run++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bus_owner: chip select with no grant expected at cycle %0d", cyc);
        end else begin
          m = int'(exp_q[0].m);
          if ({o_mem_addr, o_mem_we, o_mem_dat} !== {addr[m], we[m], dat[m]}) begin
            n_err++;
            $display("FAIL bus_pins m%0d: got addr=%h we=%b dat=%h expected addr=%h we=%b dat=%h",
                     m, o_mem_addr, o_mem_we, o_mem_dat, addr[m], we[m], dat[m]);
          end
        end
      end else begin
        if (cs_run != 0) begin
          n_vec++;
          if (cs_run != WS + 1) begin
            n_err++;
            $display("FAIL cs_width: got %0d cycles expected %0d", cs_run, WS + 1);
          end
          cs_run = 0;
        end
        n_vec++;
        if ({o_mem_addr, o_mem_we, o_mem_dat} !== 25'd0) begin
          n_err++;
          $display("FAIL bus_idle: got addr=%h we=%b dat=%h expected zeros",
                   o_mem_addr, o_mem_we, o_mem_dat);
        end
      end
      if (acks !== 3'b000) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_ack: got acks=%b expected none", acks);
        end else begin
          e = exp_q.pop_front();
          if (acks !== (3'b001 << e.m) || o_rdat !== e.rdat) begin
            n_err++;
            $display("FAIL ack: got acks=%b rdat=%h expected acks=%b rdat=%h",
                     acks, o_rdat, 3'b001 << e.m, e.rdat);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Wait for n acks (optionally checking their spacing), then drop every request.
  task automatic wait_acks(input int n, input int spacing, input int budget);
    int got = 0;
    int prev = -1;
    for (int t = 0; t < budget && got < n; t++) begin
      @(negedge i_clk);
      if ({o_m2_ack, o_m1_ack, o_m0_ack} !== 3'b000) begin
        got++;
        if (got == 1) first_ack_cyc = cyc;
        if (spacing != 0 && prev >= 0) begin
          n_vec++;
          if (cyc - prev != spacing) begin
            n_err++;
            $display("FAIL ack_spacing: got %0d cycles expected %0d", cyc - prev, spacing);
          end
        end
        prev = cyc;
      end
    end
    req = 3'b000;
    n_vec++;
    if (got < n) begin
      n_err++;
      $display("FAIL ack_timeout: got %0d acks expected %0d", got, n);
    end
  endtask

  task automatic check_drained(input string name);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained: got %0d pending grants expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    req = 3'b000;
    we  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr[i] = 16'h0000;
      dat[i]  = 8'h00;
    end
    i_reset_n = 1'b0;
    idle(2);
    n_vec++;
    if (all_outs() !== 38'd0) begin
      n_err++;
      $display("FAIL reset_outs: got %h expected 0", all_outs());
    end
    i_reset_n = 1'b1;
    idle(2);
    n_vec++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b expected 0", o_busy);
    end
  endtask

  task automatic test_single_read();
    int req_cyc;
    addr[0] = 16'h1234;
    we[0]   = 1'b0;
    exp_q.push_back(mk(0, 16'h1234));
    req[0]  = 1'b1;
    req_cyc = cyc;
    wait_acks(1, 0, 20);
    n_vec++;
    if (first_ack_cyc - req_cyc != WS + 2) begin
      n_err++;
      $display("FAIL read_latency: got %0d expected %0d", first_ack_cyc - req_cyc, WS + 2);
    end
    n_vec++;
    if (o_rdat !== 8'hA5) begin
      n_err++;
      $display("FAIL read_data: got %h expected a5", o_rdat);
    end
    idle(2);
    check_drained("single_read");
  endtask

  task automatic test_dma_write();
    exp_t e;
    addr[2] = 16'h8000;
    dat[2]  = 8'h3C;
    we[2]   = 1'b1;
    e.m     = 2'd2;
    e.rdat  = 8'hA5;  // read data register keeps the previous read
    exp_q.push_back(e);
    req[2]  = 1'b1;
    wait_acks(1, 0, 20);
    idle(2);
    we[2] = 1'b0;
    check_drained("dma_write");
  endtask

  task automatic test_round_robin();
    addr[0] = 16'h0102;
    addr[2] = 16'h0304;
    for (int i = 0; i < 4; i++)
      exp_q.push_back(mk((i % 2 == 0) ? 0 : 2, (i % 2 == 0) ? addr[0] : addr[2]));
    req = 3'b101;
    wait_acks(4, SPACE, 60);
    idle(2);
    check_drained("round_robin");
  endtask

  task automatic test_video_burst();
    addr[0] = 16'h1234;
    addr[1] = 16'h4000;
    we[1]   = 1'b0;
    for (int i = 0; i < 2 * VB + 1; i++)
      exp_q.push_back(mk((i == VB) ? 0 : 1, (i == VB) ? addr[0] : addr[1]));
    req = 3'b011;
    wait_acks(2 * VB + 1, SPACE, 100);
    idle(2);
    check_drained("video_burst");
    // Video alone keeps the bus even with its burst counter saturated.
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(1, addr[1]));
    req = 3'b010;
    wait_acks(6, SPACE, 60);
    idle(2);
    check_drained("video_only");
    // With the counter saturated, a CPU request wins the next slot.
    exp_q.push_back(mk(0, addr[0]));
    req = 3'b011;
    wait_acks(1, 0, 20);
    idle(2);
    check_drained("video_saturated");
  endtask

  task automatic test_drop_req();
    addr[0] = 16'h00FF;
    exp_q.push_back(mk(0, addr[0]));
    req[0] = 1'b1;
    @(negedge i_clk);
    n_vec++;
    if (o_mem_cs !== 1'b1) begin
      n_err++;
      $display("FAIL drop_access: got cs=%b expected 1", o_mem_cs);
    end
    req[0] = 1'b0;
    wait_acks(1, 0, 20);
    @(negedge i_clk);
    n_vec++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL drop_idle: got busy=%b expected 0", o_busy);
    end
    idle(3);
    check_drained("drop_req");
  endtask

  task automatic test_reset_mid_access();
    addr[0] = 16'h0010;
    addr[2] = 16'h0020;
    exp_q.push_back(mk(0, addr[0]));
    req = 3'b001;
    @(negedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    n_vec++;
    if (all_outs() !== 38'd0) begin
      n_err++;
      $display("FAIL reset_abort: got %h expected 0", all_outs());
    end
    exp_q.delete();
    req = 3'b101;
    idle(2);
    n_vec++;
    if (all_outs() !== 38'd0) begin
      n_err++;
      $display("FAIL reset_hold: got %h expected 0", all_outs());
    end
    exp_q.push_back(mk(0, addr[0]));
    i_reset_n = 1'b1;
    wait_acks(1, 0, 20);
    idle(3);
    check_drained("reset_mid_access");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_dma_write();
    test_round_robin();
    test_video_burst();
    test_drop_req();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
